// File: rtl/aes_arb_pkg.sv
// ---------------------------------------------------------------------------
// aes_arb_pkg
// Shared definitions for the two-requester AES core arbiter.
//   arb_state_e : arbiter sequencing states (IDLE/START/BUSY/RELEASE)
//   OWNER_A/B   : encoding of the requester that owns the core, also used
//                 directly as the operand-mux select value
//   pick_owner  : tie-break rule applied when the core is free
// ---------------------------------------------------------------------------
package aes_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    START   = 2'b01,
    BUSY    = 2'b10,
    RELEASE = 2'b11
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // A lone requester always wins. When both are asking, the one that was not
  // served most recently wins, so neither side can starve the other.
  function automatic logic pick_owner(input logic reqA,
                                      input logic reqB,
                                      input logic lastOwner);
    logic owner;
    owner = OWNER_A;
    if (reqA && reqB) begin
      owner = ~lastOwner;
    end else if (reqB) begin
      owner = OWNER_B;
    end
    return owner;
  endfunction

endpackage

// File: rtl/aes_arb_watchdog.sv
// ---------------------------------------------------------------------------
// aes_arb_watchdog
// Counts cycles spent waiting on the AES core and flags when the wait limit
// has been reached.
//   clk    : system clock, rising edge
//   rst    : asynchronous, active-high reset (count returns to 0)
//   clr    : synchronous clear, has priority over en
//   en     : advance the count by one this cycle
//   expire : high while the count equals TIMEOUT-1
// ---------------------------------------------------------------------------
module aes_arb_watchdog #(
  parameter  int TIMEOUT = 32,
  localparam int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] r_count;

  // Free-running wait counter. The arbiter leaves BUSY as soon as expire is
  // seen, so the count never needs to saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expire = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter
// Shares a single AES core between requesters A and B. The winner is granted,
// the core gets a one-cycle start pulse, the arbiter waits for core_done (or
// a watchdog expiry), pulses completion to the owner, then inserts one dead
// cycle before the next grant.
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   req_a, req_b    : level requests, held until the matching done pulse
//   core_done       : single-cycle completion pulse from the AES core
//   gnt_a, gnt_b    : ownership flags, never both high
//   core_sel        : operand mux select (0 = A, 1 = B), held between grants
//   core_start      : single-cycle start pulse to the core
//   done_a, done_b  : single-cycle completion pulses to the owner
//   timeout_err     : single-cycle pulse when the watchdog aborts a wait
//   last_owner      : requester served most recently (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic core_done,
  output logic gnt_a,
  output logic gnt_b,
  output logic core_sel,
  output logic core_start,
  output logic done_a,
  output logic done_b,
  output logic timeout_err,
  output logic last_owner
);

  arb_state_e r_state;
  logic       r_owner;
  logic       r_lastOwner;
  logic       r_gntA;
  logic       r_gntB;
  logic       r_coreStart;
  logic       r_doneA;
  logic       r_doneB;
  logic       r_timeoutErr;

  logic       w_nextOwner;
  logic       w_wdClr;
  logic       w_wdEn;
  logic       w_expire;

  assign w_nextOwner = pick_owner(req_a, req_b, r_lastOwner);

  // The wait count restarts while the start pulse is being issued, so it
  // reads 0 on the first BUSY cycle and reaches TIMEOUT-1 on the last one.
  assign w_wdClr = (r_state == START);
  assign w_wdEn  = (r_state == BUSY);

  aes_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_wdClr),
    .en     (w_wdEn),
    .expire (w_expire)
  );

  // Sequencing FSM with every output registered. Pulse outputs default low
  // each cycle and are raised only on the transition that owns them.
  // core_done wins over a coincident watchdog expiry, and last_owner is
  // updated on either kind of finish so alternation stays fair after an
  // aborted operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWNER_A;
      r_lastOwner  <= OWNER_B;
      r_gntA       <= 1'b0;
      r_gntB       <= 1'b0;
      r_coreStart  <= 1'b0;
      r_doneA      <= 1'b0;
      r_doneB      <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_coreStart  <= 1'b0;
      r_doneA      <= 1'b0;
      r_doneB      <= 1'b0;
      r_timeoutErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_a || req_b) begin
            r_owner <= w_nextOwner;
            r_gntA  <= (w_nextOwner == OWNER_A);
            r_gntB  <= (w_nextOwner == OWNER_B);
            r_state <= START;
          end
        end
        START: begin
          r_coreStart <= 1'b1;
          r_state     <= BUSY;
        end
        BUSY: begin
          if (core_done || w_expire) begin
            r_gntA       <= 1'b0;
            r_gntB       <= 1'b0;
            r_lastOwner  <= r_owner;
            r_doneA      <= core_done && (r_owner == OWNER_A);
            r_doneB      <= core_done && (r_owner == OWNER_B);
            r_timeoutErr <= ~core_done;
            r_state      <= RELEASE;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt_a       = r_gntA;
  assign gnt_b       = r_gntB;
  assign core_sel    = r_owner;
  assign core_start  = r_coreStart;
  assign done_a      = r_doneA;
  assign done_b      = r_doneB;
  assign timeout_err = r_timeoutErr;
  assign last_owner  = r_lastOwner;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_core_arbiter
// Self-checking bench for aes_core_arbiter with a short watchdog. A
// transaction-level model tracks who owns the core and how many edges have
// passed since the grant; every output is compared against it on each
// falling edge. Directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_aes_core_arbiter;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic core_done = 1'b0;
  logic gnt_a, gnt_b, core_sel, core_start;
  logic done_a, done_b, timeout_err, last_owner;

  int nVectors = 0;
  int nMiscompares = 0;
  bit modelLive = 1'b0;
  bit ok;
  bit ra, rb, cd;
  int cycles;

  aes_core_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
    .core_done   (core_done),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .core_sel    (core_sel),
    .core_start  (core_start),
    .done_a      (done_a),
    .done_b      (done_b),
    .timeout_err (timeout_err),
    .last_owner  (last_owner)
  );

  always #5 clk = ~clk;

  // Reference model: an operation is "busy" from its grant until it
  // finishes, "age" counts edges since the grant (edge 1 issues start,
  // edge 2 onward are waiting edges), and a finished operation leaves one
  // dead cycle before a new grant can be made.
  typedef struct {
    bit busy;
    bit dead;
    bit owner;
    bit last;
    int age;
    bit gntA;
    bit gntB;
    bit start;
    bit doneA;
    bit doneB;
    bit tmo;
  } model_t;

  model_t m;

  function automatic model_t modelReset();
    model_t r;
    r.busy = 0; r.dead = 0; r.owner = 0; r.last = 1; r.age = 0;
    r.gntA = 0; r.gntB = 0; r.start = 0; r.doneA = 0; r.doneB = 0; r.tmo = 0;
    return r;
  endfunction

  function automatic model_t modelStep(model_t cur, bit ra_i, bit rb_i, bit cd_i);
    model_t n;
    int waited;
    n = cur;
    n.start = 0; n.doneA = 0; n.doneB = 0; n.tmo = 0;
    if (cur.dead) begin
      n.dead = 0;
    end else if (!cur.busy) begin
      if (ra_i || rb_i) begin
        n.busy  = 1;
        n.owner = (ra_i && rb_i) ? !cur.last : rb_i;
        n.age   = 0;
        n.gntA  = !n.owner;
        n.gntB  = n.owner;
      end
    end else begin
      n.age = cur.age + 1;
      if (n.age == 1) begin
        n.start = 1;
      end else begin
        waited = n.age - 2;
        if (cd_i || waited == TIMEOUT - 1) begin
          n.busy  = 0;
          n.dead  = 1;
          n.gntA  = 0;
          n.gntB  = 0;
          n.last  = cur.owner;
          n.doneA = cd_i && !cur.owner;
          n.doneB = cd_i && cur.owner;
          n.tmo   = !cd_i;
        end
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUT; inputs only change 1 time
  // unit after a rising edge, so there is no race on the sampled values.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= modelReset();
    else     m <= modelStep(m, req_a, req_b, core_done);
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Full output comparison against the model once per cycle.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("gnt_a",       gnt_a,       m.gntA);
      checkOutput("gnt_b",       gnt_b,       m.gntB);
      checkOutput("core_sel",    core_sel,    m.owner);
      checkOutput("core_start",  core_start,  m.start);
      checkOutput("done_a",      done_a,      m.doneA);
      checkOutput("done_b",      done_b,      m.doneB);
      checkOutput("timeout_err", timeout_err, m.tmo);
      checkOutput("last_owner",  last_owner,  m.last);
      checkOutput("grant_onehot", gnt_a & gnt_b, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit d);
    req_a     = a;
    req_b     = b;
    core_done = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitStart(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (core_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("core_start_seen", core_start, 1'b1);
  endtask

  task automatic finishRun();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  endtask

  // Safety net so the run always ends even if the DUT stalls.
  initial begin
    #300000;
    nMiscompares++;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    finishRun();
  end

  initial begin
    applyStimulus(0, 0, 0);
    #2 rst = 1'b1;
    tick();
    modelLive = 1'b1;
    rst = 1'b0;

    // Reset state and a single request from A.
    checkOutput("rst_last_owner", last_owner, 1'b1);
    checkOutput("rst_gnt_a", gnt_a, 1'b0);
    applyStimulus(1, 0, 0);
    tick();
    checkOutput("s1_gnt_a", gnt_a, 1'b1);
    checkOutput("s1_start_later", core_start, 1'b0);
    tick();
    checkOutput("s1_core_start", core_start, 1'b1);
    repeat (4) tick();
    applyStimulus(1, 0, 1);
    tick();
    checkOutput("s1_done_a", done_a, 1'b1);
    checkOutput("s1_gnt_a_low", gnt_a, 1'b0);
    checkOutput("s1_last_owner", last_owner, 1'b0);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("s1_done_a_pulse", done_a, 1'b0);

    // Both held continuously: grants alternate A, B, A, B with a dead cycle.
    doReset();
    applyStimulus(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      waitStart(ok);
      checkOutput("s2_gnt_a", gnt_a, (k % 2) == 0);
      checkOutput("s2_gnt_b", gnt_b, (k % 2) == 1);
      repeat (2) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      checkOutput("s2_done", (k % 2) == 0 ? done_a : done_b, 1'b1);
      tick();
      checkOutput("s2_dead_cycle", gnt_a | gnt_b, 1'b0);
    end
    applyStimulus(0, 0, 0);
    repeat (2) tick();

    // B alone, core never answers: watchdog fires 8 cycles after start.
    doReset();
    applyStimulus(0, 1, 0);
    waitStart(ok);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cycles++;
      if (timeout_err === 1'b1) break;
    end
    checkOutput("s3_timeout_err", timeout_err, 1'b1);
    checkCount("s3_timeout_cycles", cycles, 8);
    checkOutput("s3_no_done_b", done_b, 1'b0);
    checkOutput("s3_last_owner", last_owner, 1'b1);
    applyStimulus(0, 0, 0);
    repeat (2) tick();
    checkOutput("s3_idle_gnt_b", gnt_b, 1'b0);

    // core_done on the same edge the watchdog would expire: done wins.
    doReset();
    applyStimulus(1, 0, 0);
    waitStart(ok);
    repeat (7) tick();
    applyStimulus(1, 0, 1);
    tick();
    checkOutput("s4_done_a", done_a, 1'b1);
    checkOutput("s4_no_timeout", timeout_err, 1'b0);
    applyStimulus(0, 0, 0);
    repeat (2) tick();

    // Asynchronous reset mid-BUSY, then A wins the first tie again; A drops
    // its request during BUSY but still gets done, and pending B is next.
    doReset();
    applyStimulus(1, 1, 0);
    waitStart(ok);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("s5_async_gnt_a", gnt_a, 1'b0);
    checkOutput("s5_async_last", last_owner, 1'b1);
    tick();
    rst = 1'b0;
    waitStart(ok);
    checkOutput("s5_first_gnt_a", gnt_a, 1'b1);
    tick();
    applyStimulus(0, 1, 0);
    repeat (2) tick();
    applyStimulus(0, 1, 1);
    tick();
    applyStimulus(0, 1, 0);
    checkOutput("s6_done_a", done_a, 1'b1);
    waitStart(ok);
    checkOutput("s6_gnt_b", gnt_b, 1'b1);
    repeat (2) tick();
    applyStimulus(0, 1, 1);
    tick();
    checkOutput("s6_done_b", done_b, 1'b1);
    applyStimulus(0, 0, 0);
    repeat (2) tick();

    // Randomised traffic obeying the request protocol.
    ra = 0; rb = 0;
    for (int i = 0; i < 800; i++) begin
      if (done_a === 1'b1 || (timeout_err === 1'b1 && core_sel === 1'b0)) ra = 0;
      else if (!ra && ($urandom % 4) == 0) ra = 1;
      if (done_b === 1'b1 || (timeout_err === 1'b1 && core_sel === 1'b1)) rb = 0;
      else if (!rb && ($urandom % 4) == 0) rb = 1;
      cd = (($urandom % 6) == 0);
      applyStimulus(ra, rb, cd);
      if (($urandom % 250) == 0) begin
        doReset();
        ra = 0; rb = 0;
        applyStimulus(0, 0, 0);
      end else begin
        tick();
      end
    end
    applyStimulus(0, 0, 0);
    repeat (3) tick();
    @(negedge clk);
    #1;
    finishRun();
  end

endmodule
